// File: rtl/mesh_pkg.sv
// Shared helpers for the mesh N-lane serializer: width functions and drain-state encoding.
package mesh_pkg;

  typedef enum logic {
    FRESH   = 1'b0,
    PARTIAL = 1'b1
  } drain_state_t;

  // Coordinate width, never narrower than one bit even for a single row/column.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of one packed lane record {valid, dst_x, dst_y, payload}.
  function automatic int lane_rec_w(input int w, input int xw, input int yw);
    return 1 + xw + yw + w;
  endfunction

endpackage

// File: rtl/mesh_multi_fifo_lane_pick.sv
// Combinational lane picker: first set bit of mask at or after start, wrapping.
module mesh_lane_pick #(
  parameter  int LANES = 4,
  localparam int LW    = $clog2(LANES)
) (
  input  logic [LANES-1:0] mask,
  input  logic [LW-1:0]    start,
  output logic [LANES-1:0] onehot,
  output logic [LW-1:0]    index,
  output logic             any
);

  always_comb begin
    int k;
    k      = 0;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      k = (int'(start) + i) % LANES;
      if (!any && mask[k]) begin
        any       = 1'b1;
        index     = LW'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_multi_fifo.sv
// Buffered N-lane to 1-lane serializer toward the mesh router.
// Optional round-robin drain order enabled by defining MESH_MULTI_FIFO_RR_EN.
module mesh_multi_fifo
  import mesh_pkg::*;
#(
  parameter  int W      = 8,
  parameter  int X_SIZE = 4,
  parameter  int Y_SIZE = 4,
  parameter  int LANES  = 4,
  parameter  int DEPTH  = 4,
  localparam int XW     = clog2_min1(X_SIZE),
  localparam int YW     = clog2_min1(Y_SIZE),
  localparam int LW     = $clog2(LANES),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES-1:0]   i_valid,
  input  logic [LANES*XW-1:0] i_dst_x,
  input  logic [LANES*YW-1:0] i_dst_y,
  input  logic [LANES*W-1:0] i_payload,
  output logic               i_ready,
  output logic               o_valid,
  output logic [XW-1:0]      o_dst_x,
  output logic [YW-1:0]      o_dst_y,
  output logic [W-1:0]       o_payload,
  output logic [LW-1:0]      o_lane,
  output logic               o_last,
  input  logic               o_ready,
  output logic [CW-1:0]      o_count
);

  localparam int REC_W = lane_rec_w(W, XW, YW);
  localparam int AW    = $clog2(DEPTH);

  logic [LANES*REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  logic [LANES-1:0]       pend_mask;
  drain_state_t           state;

  logic [LANES*REC_W-1:0] wr_entry, head;
  logic [LANES-1:0]       head_mask, live, onehot;
  logic [LW-1:0]          idx, start;
  logic                   any, show, push, hs, pop;
  logic [REC_W-2:0]       sel_data;

  always_comb begin
    wr_entry = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_entry[k*REC_W +: REC_W] = {i_valid[k], i_dst_x[k*XW +: XW],
                                    i_dst_y[k*YW +: YW], i_payload[k*W +: W]};
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    head_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      head_mask[k] = head[k*REC_W + REC_W - 1];
    end
  end

  // A fresh head drains from its stored mask; a partly drained one from the pending register.
  assign live = (state == FRESH) ? head_mask : pend_mask;

  mesh_lane_pick #(.LANES(LANES)) u_pick (
    .mask   (live),
    .start  (start),
    .onehot (onehot),
    .index  (idx),
    .any    (any)
  );

  assign sel_data  = head[idx*REC_W +: REC_W-1];
  assign o_valid   = (count != '0);
  assign show      = o_valid && any;
  assign o_payload = show ? sel_data[W-1:0]       : '0;
  assign o_dst_y   = show ? sel_data[W +: YW]     : '0;
  assign o_dst_x   = show ? sel_data[W+YW +: XW]  : '0;
  assign o_lane    = show ? idx                   : '0;
  assign o_last    = show && ((live & ~onehot) == '0);
  assign o_count   = count;

  // Space is judged from the registered count only, so a pop never admits a beat in the same cycle.
  assign i_ready = (count < CW'(DEPTH));
  assign push    = (|i_valid) && i_ready;
  assign hs      = o_valid && o_ready;
  assign pop     = hs && o_last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend_mask <= '0;
      state     <= FRESH;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (hs) begin
        if (o_last) begin
          state     <= FRESH;
          pend_mask <= '0;
        end else begin
          state     <= PARTIAL;
          pend_mask <= live & ~onehot;
        end
      end
    end
  end

`ifdef MESH_MULTI_FIFO_RR_EN
  logic [LW-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (idx == LW'(LANES - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

endmodule

// File: tb/tb_mesh_multi_fifo.sv
// Scoreboard bench for mesh_multi_fifo: directed scenarios plus randomized traffic.
module tb_mesh_multi_fifo;

  localparam int W     = 8;
  localparam int XS    = 4;
  localparam int YS    = 4;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int XW    = 2;
  localparam int YW    = 2;
  localparam int LW    = 2;
  localparam int CW    = 3;

  logic                 clk, rst_n;
  logic [LANES-1:0]     i_valid;
  logic [LANES*XW-1:0]  i_dst_x;
  logic [LANES*YW-1:0]  i_dst_y;
  logic [LANES*W-1:0]   i_payload;
  logic                 i_ready, o_valid, o_last, o_ready;
  logic [XW-1:0]        o_dst_x;
  logic [YW-1:0]        o_dst_y;
  logic [W-1:0]         o_payload;
  logic [LW-1:0]        o_lane;
  logic [CW-1:0]        o_count;

  mesh_multi_fifo #(.W(W), .X_SIZE(XS), .Y_SIZE(YS), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_dst_x(i_dst_x), .i_dst_y(i_dst_y),
    .i_payload(i_payload), .i_ready(i_ready), .o_valid(o_valid), .o_dst_x(o_dst_x),
    .o_dst_y(o_dst_y), .o_payload(o_payload), .o_lane(o_lane), .o_last(o_last),
    .o_ready(o_ready), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [W-1:0]  p;
    int            lane;
    bit            last;
  } pkt_t;

  pkt_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mcount   = 0;
  int   mrr      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted beat yields its set lanes in drain order, last tag on the final one.
  task automatic expect_beat(input logic [LANES-1:0] m, input logic [LANES*XW-1:0] xv,
                             input logic [LANES*YW-1:0] yv, input logic [LANES*W-1:0] pv);
    int order[$];
    int st;
    pkt_t e;
`ifdef MESH_MULTI_FIFO_RR_EN
    st = mrr;
`else
    st = 0;
`endif
    for (int i = 0; i < LANES; i++) begin
      int k;
      k = (st + i) % LANES;
      if (m[k]) order.push_back(k);
    end
    for (int j = 0; j < order.size(); j++) begin
      e.x    = xv[order[j]*XW +: XW];
      e.y    = yv[order[j]*YW +: YW];
      e.p    = pv[order[j]*W +: W];
      e.lane = order[j];
      e.last = (j == order.size() - 1);
      sb.push_back(e);
    end
`ifdef MESH_MULTI_FIFO_RR_EN
    mrr = (order[order.size()-1] + 1) % LANES;
`endif
  endtask

  logic        pv_valid, pv_ready;
  logic [63:0] pv_vec;
  int          pushed, popped;
  pkt_t        got;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mcount   = 0;
      mrr      = 0;
      pv_valid = 1'b0;
      pv_ready = 1'b0;
    end else begin
      check("o_count", o_count, mcount);
      check("i_ready", i_ready, mcount < DEPTH);
      check("o_valid", o_valid, mcount != 0);
      if (!o_valid) check("idle_outputs", {o_payload, o_lane, o_last, o_dst_x, o_dst_y}, 0);
      if (pv_valid && !pv_ready)
        check("stall_hold", {o_valid, o_payload, o_lane, o_last, o_dst_x, o_dst_y}, pv_vec);
      popped = 0;
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          got = sb.pop_front();
          check("out_lane", o_lane, got.lane);
          check("out_dst_x", o_dst_x, got.x);
          check("out_dst_y", o_dst_y, got.y);
          check("out_payload", o_payload, got.p);
          check("out_last", o_last, got.last);
          if (got.last) popped = 1;
        end
      end
      pushed = 0;
      if ((|i_valid) && mcount < DEPTH) begin
        expect_beat(i_valid, i_dst_x, i_dst_y, i_payload);
        pushed = 1;
      end
      mcount   = mcount + pushed - popped;
      pv_valid = o_valid;
      pv_ready = o_ready;
      pv_vec   = {48'd0, o_valid, o_payload, o_lane, o_last, o_dst_x, o_dst_y};
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [LANES-1:0] m, input logic [LANES*W-1:0] p);
    i_valid   = m;
    i_dst_x   = (LANES*XW)'($urandom);
    i_dst_y   = (LANES*YW)'($urandom);
    i_payload = p;
    cycle();
    i_valid   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst_n = 1'b0; i_valid = '0; i_dst_x = '0; i_dst_y = '0; i_payload = '0; o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_valid", o_valid, 0);
    check("reset_o_count", o_count, 0);
    check("reset_i_ready", i_ready, 1);
    check("reset_data", {o_payload, o_lane, o_last, o_dst_x, o_dst_y}, 0);
    rst_n = 1'b1;
    cycle();

    // Reset in the middle of draining an entry.
    beat(4'b1011, 32'h13121110);
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_o_valid", o_valid, 0);
    check("async_rst_o_count", o_count, 0);
    check("async_rst_i_ready", i_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cycle();

    // Single beat, continuous drain.
    o_ready = 1'b1;
    beat(4'b1011, 32'h13121110);
    repeat (5) cycle();

    // Fill to capacity, reject a fifth beat, then one last-lane pop.
    o_ready = 1'b0;
    beat(4'b1000, (LANES*W)'($urandom));
    for (int b = 0; b < 3; b++) beat(4'($urandom_range(1, 15)), (LANES*W)'($urandom));
    i_valid = 4'b1111;
    i_payload = (LANES*W)'($urandom);
    check("full_count", o_count, 4);
    check("full_i_ready", i_ready, 0);
    cycle();
    i_valid = '0;
    o_ready = 1'b1;
    cycle();
    o_ready = 1'b0;
    check("after_pop_i_ready", i_ready, 1);
    o_ready = 1'b1;
    repeat (20) cycle();

    // Backpressure across a two-lane entry.
    o_ready = 1'b0;
    beat(4'b0110, 32'hA4A3A2A1);
    o_ready = 1'b1; cycle();
    o_ready = 1'b0; cycle();
    o_ready = 1'b0; cycle();
    o_ready = 1'b1; cycle();
    repeat (3) cycle();

    // Empty-mask beats never occupy an entry.
    beat(4'b0000, 32'hFFFFFFFF);
    beat(4'b0000, 32'h01020304);
    check("empty_beat_count", o_count, 0);

`ifdef MESH_MULTI_FIFO_RR_EN
    o_ready = 1'b1;
    beat(4'b1111, 32'h23222120);
    beat(4'b1111, 32'h33323130);
    repeat (10) cycle();
    o_ready = 1'b0;
    beat(4'b1111, 32'h43424140);
    o_ready = 1'b1;
    beat(4'b0011, 32'h53525150);
    o_ready = 1'b0;
    repeat (2) cycle();
    o_ready = 1'b1;
    repeat (10) cycle();
`endif

    // Randomized traffic with varying backpressure.
    for (int n = 0; n < 600; n++) begin
      i_valid   = ($urandom_range(0, 3) == 0) ? '0 : LANES'($urandom);
      i_dst_x   = (LANES*XW)'($urandom);
      i_dst_y   = (LANES*YW)'($urandom);
      i_payload = (LANES*W)'($urandom);
      o_ready   = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
    end

    i_valid = '0;
    o_ready = 1'b1;
    guard = 0;
    while ((mcount != 0 || sb.size() != 0) && guard < 200) begin
      cycle();
      guard++;
    end
    check("drain_scoreboard_empty", sb.size(), 0);
    check("drain_o_count", o_count, 0);
    check("drain_o_valid", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
